// File: rtl/transmit_delay_scheduler_pkg.sv
// Shared types, widths and the delay rounding helper for the transmit delay scheduler.
package transmit_delay_scheduler_pkg;

  localparam int unsigned TDS_DW_N_INTEGER     = 13;
  localparam int unsigned TDS_DW_ERROR_INTEGER = 14;
  localparam int unsigned TDS_DW_FRACTION      = 4;
  localparam int unsigned TDS_N_W              = TDS_DW_N_INTEGER + TDS_DW_FRACTION + 1;
  localparam int unsigned TDS_ERR_W            = TDS_DW_ERROR_INTEGER + TDS_DW_FRACTION + 1;
  localparam int unsigned TDS_D_W              = TDS_DW_N_INTEGER + 1;

  typedef logic        [TDS_N_W-1:0]   n_t;
  typedef logic signed [TDS_ERR_W-1:0] err_t;
  typedef logic        [TDS_D_W-1:0]   delay_int_t;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_READY = 3'd1,
    CAPTURE    = 3'd2,
    FIRE       = 3'd3,
    DONE       = 3'd4
  } state_t;

  // Round half up: integer part plus the most significant fraction bit.
  // The top bit of n is a guard bit and never set for legal delays, so the
  // largest result is 2^DW_N_INTEGER, which still fits delay_int_t.
  function automatic delay_int_t round_delay(input n_t n);
    return delay_int_t'(n[TDS_N_W-2:TDS_DW_FRACTION]) + delay_int_t'(n[TDS_DW_FRACTION-1]);
  endfunction

endpackage

// File: rtl/transmit_delay_scheduler_timer.sv
// Per-element timer: holds the rounded delay and the fired flag, pulses fire once.
module transmit_element_timer
  import transmit_delay_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  n_t         n,
  input  delay_int_t counter,
  input  logic       active,
  output logic       fire,
  output logic       fired
);

  delay_int_t r_delay;
  logic       r_fired;

  // Fire exactly once, when the shared counter reaches this element's delay.
  always_comb begin
    fire  = active && (counter == r_delay) && !r_fired;
    fired = r_fired;
  end

  // Load the rounded delay on capture, then latch that the element has fired.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_delay <= '0;
      r_fired <= 1'b0;
    end else if (load) begin
      r_delay <= round_delay(n);
      r_fired <= 1'b0;
    end else if (fire) begin
      r_fired <= 1'b1;
    end
  end

endmodule

// File: rtl/transmit_delay_scheduler.sv
// Consumer of the delay array handshake: captures delays, fires per-element
// transmit pulses at their rounded delays and sequences scan points.
module transmit_delay_scheduler
  import transmit_delay_scheduler_pkg::*;
#(
  parameter int unsigned NUM_ELEMENTS     = 64,
  parameter int unsigned DW_N_INTEGER     = TDS_DW_N_INTEGER,
  parameter int unsigned DW_ERROR_INTEGER = TDS_DW_ERROR_INTEGER,
  parameter int unsigned DW_FRACTION      = TDS_DW_FRACTION,
  parameter int unsigned DW_POINTS        = 8
)(
  input  logic                                                         clk,
  input  logic                                                         rst,
  input  logic                                                         start,
  input  logic                                                         abort,
  input  logic [DW_POINTS-1:0]                                         num_points,
  input  logic [NUM_ELEMENTS-1:0][DW_N_INTEGER+DW_FRACTION:0]          n_in,
  input  logic [NUM_ELEMENTS-1:0][DW_ERROR_INTEGER+DW_FRACTION:0]      error_in,
  input  logic                                                         ready_in,
  output logic                                                         ack_out,
  output logic [NUM_ELEMENTS-1:0][DW_N_INTEGER+DW_FRACTION:0]          n_prev,
  output logic [NUM_ELEMENTS-1:0][DW_ERROR_INTEGER+DW_FRACTION:0]      error_prev,
  output logic [NUM_ELEMENTS-1:0]                                      fire,
  output logic                                                         transmit_done,
  output logic                                                         final_scanpoint,
  output logic                                                         busy
);

  state_t                                                    r_state;
  delay_int_t                                                r_counter;
  logic [DW_POINTS-1:0]                                      r_point_cnt;
  logic [DW_POINTS-1:0]                                      r_last_point;
  logic [NUM_ELEMENTS-1:0][DW_N_INTEGER+DW_FRACTION:0]       r_n_prev;
  logic [NUM_ELEMENTS-1:0][DW_ERROR_INTEGER+DW_FRACTION:0]   r_err_prev;
  logic [NUM_ELEMENTS-1:0]                                   w_fire;
  logic [NUM_ELEMENTS-1:0]                                   w_fired;
  logic                                                      w_load;
  logic                                                      w_active;
  logic                                                      w_all_fired;
  logic                                                      w_last;

  for (genvar g = 0; g < NUM_ELEMENTS; g++) begin : g_elem
    transmit_element_timer u_timer (
      .clk     (clk),
      .rst     (rst),
      .load    (w_load),
      .n       (n_in[g]),
      .counter (r_counter),
      .active  (w_active),
      .fire    (w_fire[g]),
      .fired   (w_fired[g])
    );
  end

  // Decode handshake, firing and end-of-point conditions from the state.
  always_comb begin
    w_load      = (r_state == CAPTURE) && !abort;
    w_active    = (r_state == FIRE);
    w_all_fired = &(w_fired | w_fire);
    w_last      = (r_point_cnt == r_last_point);
  end

  // Scanline sequencer; abort wins over every other transition, including start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_counter    <= '0;
      r_point_cnt  <= '0;
      r_last_point <= '0;
      r_n_prev     <= '0;
      r_err_prev   <= '0;
    end else if (abort) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_last_point <= (num_points == '0) ? '0 : num_points - DW_POINTS'(1);
            r_point_cnt  <= '0;
            r_state      <= WAIT_READY;
          end
        end
        WAIT_READY: begin
          if (ready_in) r_state <= CAPTURE;
        end
        CAPTURE: begin
          r_n_prev   <= n_in;
          r_err_prev <= error_in;
          r_counter  <= '0;
          r_state    <= FIRE;
        end
        FIRE: begin
          r_counter <= r_counter + delay_int_t'(1);
          if (w_all_fired) r_state <= DONE;
        end
        DONE: begin
          if (w_last) begin
            r_point_cnt <= '0;
            r_state     <= IDLE;
          end else begin
            r_point_cnt <= r_point_cnt + DW_POINTS'(1);
            r_state     <= WAIT_READY;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Outputs are pure decodes of registered state so they drop with reset or abort.
  always_comb begin
    ack_out         = (r_state == CAPTURE);
    fire            = w_fire;
    transmit_done   = (r_state == DONE);
    final_scanpoint = (r_state == DONE) && w_last;
    busy            = (r_state != IDLE);
    n_prev          = r_n_prev;
    error_prev      = r_err_prev;
  end

endmodule

// File: tb/tb_transmit_delay_scheduler.sv
// Directed bench for transmit_delay_scheduler with four elements.
module tb_transmit_delay_scheduler;

  localparam int NE = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [7:0]       num_points = '0;
  logic [NE-1:0][17:0] n_in = '0;
  logic [NE-1:0][18:0] error_in = '0;
  logic             ready_in = 1'b0;
  logic             ack_out;
  logic [NE-1:0][17:0] n_prev;
  logic [NE-1:0][18:0] error_prev;
  logic [NE-1:0]    fire;
  logic             transmit_done;
  logic             final_scanpoint;
  logic             busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int ack_n, ack_c, done_c, fin_n;
  int fire_n [NE];
  int fire_c [NE];

  transmit_delay_scheduler #(
    .NUM_ELEMENTS (NE)
  ) u_dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .abort           (abort),
    .num_points      (num_points),
    .n_in            (n_in),
    .error_in        (error_in),
    .ready_in        (ready_in),
    .ack_out         (ack_out),
    .n_prev          (n_prev),
    .error_prev      (error_prev),
    .fire            (fire),
    .transmit_done   (transmit_done),
    .final_scanpoint (final_scanpoint),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic begin_line(input logic [7:0] np);
    num_points = np;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Record ack, fire and done timing for one scan point; returns one cycle after done.
  task automatic observe(input int budget);
    ack_n = 0; ack_c = -1; done_c = -1; fin_n = 0;
    for (int i = 0; i < NE; i++) begin fire_n[i] = 0; fire_c[i] = -1; end
    for (int k = 0; k < budget; k++) begin
      if (ack_out) begin ack_n++; ack_c = cyc; end
      for (int i = 0; i < NE; i++) if (fire[i]) begin fire_n[i]++; fire_c[i] = cyc; end
      if (final_scanpoint) fin_n++;
      if (transmit_done) begin
        done_c = cyc;
        tick();
        return;
      end
      tick();
    end
    chk("point_timeout", 0, 1);
  endtask

  task automatic wait_ack(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (ack_out) return;
      tick();
    end
    chk("ack_timeout", 0, 1);
  endtask

  initial begin
    logic [NE-1:0][17:0] nv;
    logic [NE-1:0][18:0] ev;
    int stray;

    // Reset state
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_outs", {ack_out, fire, transmit_done, final_scanpoint}, 0);
    chk("rst_nprev", n_prev, 0);
    chk("rst_eprev", error_prev, 0);
    rst = 1'b0;
    tick();

    // Basic point: d = {3,2,1,0} for elements 3..0
    nv = {18'h030, 18'h018, 18'h017, 18'h000};
    n_in = nv;
    ready_in = 1'b1;
    begin_line(8'd1);
    observe(50);
    chk("b_acks", ack_n, 1);
    chk("b_fire0", fire_c[0] - ack_c, 1);
    chk("b_fire1", fire_c[1] - ack_c, 2);
    chk("b_fire2", fire_c[2] - ack_c, 3);
    chk("b_fire3", fire_c[3] - ack_c, 4);
    chk("b_pulses", {fire_n[3][3:0], fire_n[2][3:0], fire_n[1][3:0], fire_n[0][3:0]}, 16'h1111);
    chk("b_done", done_c - ack_c, 5);
    chk("b_final", fin_n, 1);
    chk("b_busy_low", busy, 0);
    chk("b_nprev", n_prev, nv);
    ready_in = 1'b0;
    tick();

    // Equal delays: all d = 5
    nv = {4{18'h050}};
    n_in = nv;
    ready_in = 1'b1;
    begin_line(8'd1);
    observe(50);
    for (int i = 0; i < NE; i++) chk($sformatf("e_fire%0d", i), fire_c[i] - ack_c, 6);
    chk("e_pulses", {fire_n[3][3:0], fire_n[2][3:0], fire_n[1][3:0], fire_n[0][3:0]}, 16'h1111);
    chk("e_done", done_c - ack_c, 7);
    ready_in = 1'b0;
    tick();

    // Multi-point scanline with error capture, ready held through FIRE
    n_in = {4{18'h010}};
    begin_line(8'd3);
    for (int p = 0; p < 3; p++) begin
      ev = {19'(-5 - p), 19'(7 + p), 19'(p), 19'(-1)};
      error_in = ev;
      tick(); tick();
      ready_in = 1'b1;
      observe(50);
      ready_in = 1'b0;
      chk($sformatf("m_acks%0d", p), ack_n, 1);
      chk($sformatf("m_eprev%0d", p), error_prev, ev);
      chk($sformatf("m_final%0d", p), fin_n, (p == 2) ? 1 : 0);
    end
    chk("m_busy_low", busy, 0);

    // Handshake gating: ready low 10 cycles
    n_in = '0;
    begin_line(8'd1);
    stray = 0;
    for (int k = 0; k < 10; k++) begin
      if (ack_out) stray++;
      tick();
    end
    chk("g_noack_low", stray, 0);
    chk("g_busy_wait", busy, 1);
    ready_in = 1'b1;
    observe(50);
    chk("g_acks", ack_n, 1);
    stray = 0;
    for (int k = 0; k < 4; k++) begin
      if (ack_out) stray++;
      tick();
    end
    chk("g_noack_idle", stray, 0);
    ready_in = 1'b0;

    // Abort after the first element fires
    nv = {18'h030, 18'h020, 18'h010, 18'h000};
    n_in = nv;
    ready_in = 1'b1;
    begin_line(8'd1);
    wait_ack(20);
    tick();
    chk("a_first_fire", fire, 4'b0001);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    ready_in = 1'b0;
    chk("a_fire_off", fire, 0);
    chk("a_busy_off", busy, 0);
    stray = 0;
    for (int k = 0; k < 10; k++) begin
      if (fire != '0 || transmit_done || final_scanpoint) stray++;
      tick();
    end
    chk("a_no_more", stray, 0);
    chk("a_nprev", n_prev, nv);

    // Simultaneous start and abort in IDLE
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("sa_idle", busy, 0);

    // Reset mid-FIRE
    n_in = {4{18'h050}};
    error_in = {4{19'h00123}};
    ready_in = 1'b1;
    begin_line(8'd1);
    wait_ack(20);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("r_outs", {ack_out, fire, transmit_done, final_scanpoint, busy}, 0);
    chk("r_nprev", n_prev, 0);
    chk("r_eprev", error_prev, 0);
    rst = 1'b0;
    ready_in = 1'b0;
    tick();

    // Boundary: largest legal delay on element 2, num_points = 0
    nv = {18'h00000, 18'h1FFFF, 18'h00000, 18'h00000};
    n_in = nv;
    ready_in = 1'b1;
    begin_line(8'd0);
    observe(9000);
    chk("x_fire2", fire_c[2] - ack_c, 8193);
    chk("x_fire0", fire_c[0] - ack_c, 1);
    chk("x_fire3", fire_c[3] - ack_c, 1);
    chk("x_pulses", {fire_n[3][3:0], fire_n[2][3:0], fire_n[1][3:0], fire_n[0][3:0]}, 16'h1111);
    chk("x_done", done_c - ack_c, 8194);
    chk("x_np0_final", fin_n, 1);
    chk("x_busy_low", busy, 0);
    ready_in = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
